// File: rtl/vga_frame_monitor.sv
// VGA receive-side monitor: measures line/frame timing from looped-back sync pins and reports lock.
// Optional per-frame pixel checksum is built when VGA_MON_CHECKSUM_EN is defined.
module vga_frame_monitor #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CNT_W   = 11,
  parameter int LINE_W  = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [5:0]        rrggbb,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  hs_width,
  output logic [LINE_W-1:0] frame_lines,
  output logic [LINE_W-1:0] vs_width,
  output logic [15:0]       frame_sum,
  output logic              locked,
  output logic              frame_done,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0]  H_MAX = {CNT_W{1'b1}};
  localparam logic [LINE_W-1:0] V_MAX = {LINE_W{1'b1}};
  localparam logic [CNT_W-1:0]  H_EXP = CNT_W'(H_TOTAL);
  localparam logic [LINE_W-1:0] V_EXP = LINE_W'(V_TOTAL);

  state_t            state, state_nxt;
  logic [2:0]        hs_sync, vs_sync;
  logic [CNT_W-1:0]  h_cnt, hs_low_cnt;
  logic [LINE_W-1:0] v_cnt, vs_low_cnt, frame_lines_new;
  logic              frame_ok, err_event;
  logic              hs_fall, hs_rise, vs_fall, vs_rise, bad_line, bad_frame;

  // Sync flops idle high so a released reset never fabricates a sync edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hs_sync <= 3'b111;
      vs_sync <= 3'b111;
    end else begin
      hs_sync <= {hs_sync[1:0], hsync};
      vs_sync <= {vs_sync[1:0], vsync};
    end
  end

  assign hs_fall   = hs_sync[2] & ~hs_sync[1];
  assign hs_rise   = ~hs_sync[2] & hs_sync[1];
  assign vs_fall   = vs_sync[2] & ~vs_sync[1];
  assign vs_rise   = ~vs_sync[2] & vs_sync[1];
  assign bad_line  = hs_fall & (h_cnt != H_EXP);
  // A coincident hsync fall still belongs to the frame that is ending.
  assign frame_lines_new = (hs_fall && (v_cnt != V_MAX)) ? v_cnt + {{(LINE_W-1){1'b0}}, 1'b1} : v_cnt;
  assign bad_frame = vs_fall & (frame_lines_new != V_EXP);

  // Line and frame measurement counters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      h_cnt       <= '0;
      hs_low_cnt  <= '0;
      v_cnt       <= '0;
      vs_low_cnt  <= '0;
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
      vs_width    <= '0;
      frame_ok    <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_cnt    <= {{(CNT_W-1){1'b0}}, 1'b1};
        line_len <= h_cnt;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (hs_rise) begin
        hs_width   <= hs_low_cnt;
        hs_low_cnt <= '0;
      end else if (!hs_sync[1] && (hs_low_cnt != H_MAX)) begin
        hs_low_cnt <= hs_low_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (vs_fall) begin
        frame_lines <= frame_lines_new;
        v_cnt       <= '0;
      end else if (hs_fall && (v_cnt != V_MAX)) begin
        v_cnt <= v_cnt + {{(LINE_W-1){1'b0}}, 1'b1};
      end
      if (vs_rise) begin
        vs_width   <= vs_low_cnt;
        vs_low_cnt <= '0;
      end else if (hs_fall && !vs_sync[1] && (vs_low_cnt != V_MAX)) begin
        vs_low_cnt <= vs_low_cnt + {{(LINE_W-1){1'b0}}, 1'b1};
      end
      if (vs_fall) begin
        frame_ok <= 1'b1;
      end else if (bad_line) begin
        frame_ok <= 1'b0;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the closing line is judged before the frame it ends.
  always_comb begin
    state_nxt = state;
    err_event = 1'b0;
    case (state)
      IDLE: begin
        if (vs_fall) state_nxt = ACQUIRE;
        else         state_nxt = IDLE;
      end
      ACQUIRE: begin
        if (vs_fall && frame_ok && !bad_line && !bad_frame) state_nxt = LOCKED;
        else                                                  state_nxt = ACQUIRE;
      end
      LOCKED: begin
        if (bad_line || bad_frame || (h_cnt == H_MAX)) begin
          state_nxt = ACQUIRE;
          err_event = 1'b1;
        end else begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      locked     <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      locked     <= (state_nxt == LOCKED);
      frame_done <= vs_fall && (state != IDLE);
      if (err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [5:0]  rgb_s1, rgb_s2;
  logic [15:0] sum_acc;

  // Pixel checksum: the vs_fall pixel opens the next frame's sum.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rgb_s1    <= 6'd0;
      rgb_s2    <= 6'd0;
      sum_acc   <= 16'd0;
      frame_sum <= 16'd0;
    end else begin
      rgb_s1 <= rrggbb;
      rgb_s2 <= rgb_s1;
      if (vs_fall) begin
        frame_sum <= sum_acc;
        sum_acc   <= {10'd0, rgb_s2};
      end else begin
        sum_acc <= sum_acc + {10'd0, rgb_s2};
      end
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^rrggbb;
  assign frame_sum  = 16'd0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a reduced 40x12 mode (hs low 6 clocks, vs low 2 lines).
module tb_vga_frame_monitor;
  localparam int H_T = 40;
  localparam int V_T = 12;
  localparam int HS_LOW = 6;
`ifdef VGA_MON_CHECKSUM_EN
  localparam logic [15:0] SUM_3F = 16'h7620;  // 63 * 480
  localparam logic [15:0] SUM_01 = 16'h01E0;  // 1 * 480
`else
  localparam logic [15:0] SUM_3F = 16'h0000;
  localparam logic [15:0] SUM_01 = 16'h0000;
`endif

  logic        clk;
  logic        wb_rst_i;
  logic        hsync, vsync;
  logic [5:0]  rrggbb;
  logic [10:0] line_len, hs_width;
  logic [9:0]  frame_lines, vs_width;
  logic [15:0] frame_sum;
  logic        locked, frame_done;
  logic [7:0]  err_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          vs_off = 0;
  logic [5:0]  pix = 6'h3F;

  vga_frame_monitor #(.H_TOTAL(H_T), .V_TOTAL(V_T), .CNT_W(11), .LINE_W(10)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .line_len(line_len), .hs_width(hs_width), .frame_lines(frame_lines), .vs_width(vs_width),
    .frame_sum(frame_sum), .locked(locked), .frame_done(frame_done), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic line(input int len, input logic vs_lvl);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hsync = (c < HS_LOW) ? 1'b0 : 1'b1;
      if (c == vs_off) begin
        vsync  = vs_lvl;
        rrggbb = pix;
      end
    end
  endtask

  task automatic frame(input int bad, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      line((l == bad) ? H_T - 1 : H_T, (l < 2) ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; hsync = 1'b1; vsync = 1'b1; rrggbb = 6'h3F;
    tick(3);
    check("reset_meas", {line_len, hs_width, frame_lines, vs_width}, 64'd0);
    check("reset_stat", {frame_sum, locked, frame_done, err_count}, 64'd0);
    wb_rst_i = 1'b0;
    tick(2);

    frame(-1, V_T);
    check("first_vs_not_locked", locked, 64'd0);
    check("first_vs_no_done", done_cnt, 64'd0);
    frame(-1, V_T);
    check("lock_locked", locked, 64'd1);
    check("lock_line_len", line_len, 64'd40);
    check("lock_hs_width", hs_width, 64'd6);
    check("lock_frame_lines", frame_lines, 64'd12);
    check("lock_vs_width", vs_width, 64'd2);
    check("lock_err", err_count, 64'd0);
    check("lock_done_cnt", done_cnt, 64'd1);
    check("sum_3f", frame_sum, SUM_3F);

    frame(5, V_T);
    check("badline_unlocked", locked, 64'd0);
    check("badline_err", err_count, 64'd1);
    pix = 6'h01;
    frame(-1, V_T);
    check("relock_one_frame", locked, 64'd0);
    pix = 6'h3F;
    frame(-1, V_T);
    check("relock_two_frames", locked, 64'd1);
    check("relock_err", err_count, 64'd1);
    check("sum_01", frame_sum, SUM_01);
    check("relock_done_cnt", done_cnt, 64'd4);

    frame(-1, 5);
    check("pre_rst_locked", locked, 64'd1);
    wb_rst_i = 1'b1;
    tick(1);
    check("midrst_meas", {line_len, hs_width, frame_lines, vs_width}, 64'd0);
    check("midrst_stat", {frame_sum, locked, frame_done, err_count}, 64'd0);
    wb_rst_i = 1'b0;
    frame(-1, V_T);
    check("rst_one_vs", locked, 64'd0);
    frame(-1, V_T);
    check("rst_two_vs", locked, 64'd1);
    check("rst_err", err_count, 64'd0);
    check("rst_frame_lines", frame_lines, 64'd12);
    check("rst_done_cnt", done_cnt, 64'd6);

    tick(2100);
    check("lost_unlocked", locked, 64'd0);
    check("lost_err", err_count, 64'd1);
    line(H_T, 1'b1);
    check("lost_line_len", line_len, 64'd2047);
    check("lost_err_once", err_count, 64'd1);
    frame(-1, V_T);
    check("lost_reacq", locked, 64'd0);
    frame(-1, V_T);
    check("lost_relock", locked, 64'd1);

    vs_off = 20;
    frame(-1, V_T);
    frame(-1, V_T);
    check("offset_locked", locked, 64'd1);
    check("offset_frame_lines", frame_lines, 64'd12);
    check("offset_vs_width", vs_width, 64'd2);
    check("offset_err", err_count, 64'd1);
    check("offset_sum", frame_sum, SUM_3F);
    check("final_done_cnt", done_cnt, 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
